// File: rtl/vga_term_pkg.sv
// rtl/vga_term_pkg.sv - shared geometry defaults, FSM states and character codes for the text terminal
package vga_term_pkg;

    localparam int DEF_COLS = 86;
    localparam int DEF_ROWS = 32;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } term_state_t;

    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_SP       = 8'h20;
    localparam logic [7:0] CH_CURSOR   = 8'h5F;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    // Bytes that are stored in the character buffer rather than interpreted
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/vga_term_ram.sv
// rtl/vga_term_ram.sv - simple dual-port character RAM, registered read-first output
module vga_term_ram #(
    parameter int DEPTH = 2752,
    parameter int AW    = 12,
    parameter int DW    = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write and read in the same edge; the read sees the pre-write contents
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_char_terminal.sv
// rtl/vga_char_terminal.sv - scrolling text terminal answering vga_char_86x32 requests; optional blinking cursor via VGA_TERM_CURSOR_EN
module vga_char_terminal
    import vga_term_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
`ifdef VGA_TERM_CURSOR_EN
    ,
    parameter int BLINK_CYCLES = 25_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [6:0] reqx,
    input  logic [4:0] reqy,
    output logic [6:0] ascii,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    output logic [6:0] cursor_x,
    output logic [4:0] cursor_y
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [6:0]    COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);
    localparam logic [AW-1:0] CELL_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LINE_LAST = AW'(COLS - 1);

    // Screen row -> physical row, rotated by the hardware scroll offset
    function automatic logic [4:0] phys_row(input logic [4:0] y, input logic [4:0] top);
        logic [5:0] s;
        s = {1'b0, y} + {1'b0, top};
        if (s >= 6'(ROWS)) begin
            s = s - 6'(ROWS);
        end
        return s[4:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        return AW'(row) * AW'(COLS) + AW'(col);
    endfunction

    term_state_t   state;
    logic [AW-1:0] clr_ctr;
    logic [AW-1:0] clr_base;
    logic [4:0]    top_row;

    logic          accept;
    logic          printable;
    logic          newline;
    logic          scroll;
    logic [4:0]    next_top;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [6:0]    ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [6:0]    ram_rdata;

    logic          hit;
    logic          hit_q;
    logic          on_cursor;
    logic          cursor_q;

    assign accept    = wr_valid & wr_ready;
    assign printable = is_printable(wr_data);
    assign newline   = accept & ((wr_data == CH_LF) | (printable & (cursor_x == COL_LAST)));
    assign scroll    = newline & (cursor_y == ROW_LAST);
    assign next_top  = (top_row == ROW_LAST) ? 5'd0 : top_row + 5'd1;

    // Single RAM write port shared by the clear sweeps and accepted printables
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = CH_SP[6:0];
        case (state)
            CLR_ALL: begin
                ram_we    = ~rst;
                ram_waddr = clr_ctr;
            end
            CLR_LINE: begin
                ram_we    = ~rst;
                ram_waddr = clr_base + clr_ctr;
            end
            IDLE: begin
                if (accept && printable && !rst) begin
                    ram_we    = 1'b1;
                    ram_waddr = cell_addr(phys_row(cursor_y, top_row), cursor_x);
                    ram_wdata = wr_data[6:0];
                end
            end
            default: ;
        endcase
    end

    // Terminal control: clear sweeps, cursor movement and scroll offset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLR_ALL;
            clr_ctr  <= '0;
            clr_base <= '0;
            top_row  <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                CLR_ALL: begin
                    if (clr_ctr == CELL_LAST) begin
                        clr_ctr  <= '0;
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_ctr <= clr_ctr + AW'(1);
                    end
                end
                CLR_LINE: begin
                    if (clr_ctr == LINE_LAST) begin
                        clr_ctr  <= '0;
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_ctr <= clr_ctr + AW'(1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (wr_data == CH_FF) begin
                            cursor_x <= '0;
                            cursor_y <= '0;
                            top_row  <= '0;
                            clr_ctr  <= '0;
                            state    <= CLR_ALL;
                            wr_ready <= 1'b0;
                        end else if (newline) begin
                            cursor_x <= '0;
                            if (scroll) begin
                                // The old top physical row becomes the new bottom row
                                top_row  <= next_top;
                                clr_base <= cell_addr(top_row, 7'd0);
                                clr_ctr  <= '0;
                                state    <= CLR_LINE;
                                wr_ready <= 1'b0;
                            end else begin
                                cursor_y <= cursor_y + 5'd1;
                            end
                        end else if (printable) begin
                            cursor_x <= cursor_x + 7'd1;
                        end else if (wr_data == CH_CR) begin
                            cursor_x <= '0;
                        end else if ((wr_data == CH_BS) && (cursor_x != 7'd0)) begin
                            cursor_x <= cursor_x - 7'd1;
                        end
                    end
                end
                default: begin
                    state    <= CLR_ALL;
                    clr_ctr  <= '0;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign hit       = req && (int'(reqx) < COLS) && (int'(reqy) < ROWS);
    assign ram_raddr = hit ? cell_addr(phys_row(reqy, top_row), reqx) : '0;

`ifdef VGA_TERM_CURSOR_EN
    logic [31:0] blink_ctr;
    logic        blink_phase;

    // Free-running blink timer; phase flips every BLINK_CYCLES clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_ctr   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_ctr == 32'(BLINK_CYCLES - 1)) begin
            blink_ctr   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_ctr <= blink_ctr + 32'd1;
        end
    end

    assign on_cursor = blink_phase && (reqx == cursor_x) && (reqy == cursor_y);
`else
    assign on_cursor = 1'b0;
`endif

    // Request qualifiers aligned with the registered RAM output
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q    <= 1'b0;
            cursor_q <= 1'b0;
        end else begin
            hit_q    <= hit;
            cursor_q <= hit & on_cursor;
        end
    end

    assign ascii = !hit_q ? 7'd0 : (cursor_q ? CH_CURSOR[6:0] : ram_rdata);

    vga_term_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (7)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_vga_char_terminal.sv
// tb/tb_vga_char_terminal.sv - randomized self-checking bench for vga_char_terminal against a text-screen model
module tb_vga_char_terminal;

    localparam int COLS  = 86;
    localparam int ROWS  = 32;
    localparam int NCELL = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [6:0] reqx = '0;
    logic [4:0] reqy = '0;
    logic [6:0] ascii;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = '0;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;

    int checks = 0;
    int errors = 0;

    logic [6:0] scr [ROWS][COLS];
    int mx;
    int my;

    always #5 clk = ~clk;

    vga_char_terminal dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .reqx     (reqx),
        .reqy     (reqy),
        .ascii    (ascii),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 7'h20;
        mx = 0;
        my = 0;
    endtask

    task automatic model_newline(output int busy);
        busy = 0;
        mx = 0;
        if (my < ROWS - 1) begin
            my++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS-1][c] = 7'h20;
            busy = COLS;
        end
    endtask

    task automatic model_apply(input logic [7:0] b, output int busy);
        busy = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[my][mx] = b[6:0];
            if (mx == COLS - 1) model_newline(busy);
            else mx++;
        end else if (b == 8'h0A) begin
            model_newline(busy);
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0C) begin
            model_clear();
            busy = NCELL;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, output int busy);
        int w = 0;
        while (!wr_ready && w < 6000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: wr_ready=%b required 1 before byte %h", wr_ready, b);
        end
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk);
        wr_valid = 1'b0;
        model_apply(b, busy);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int busy;
        int cnt = 0;
        push_byte(b, busy);
        while (!wr_ready && cnt < 6000) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != busy) begin
            errors++;
            $display("FAIL busy_cycles byte %h: wr_ready low %0d cycles, required %0d", b, cnt, busy);
        end
        checks++;
        if (cursor_x !== 7'(mx) || cursor_y !== 5'(my)) begin
            errors++;
            $display("FAIL cursor byte %h: got (%0d,%0d) required (%0d,%0d)", b, cursor_x, cursor_y, mx, my);
        end
    endtask

    task automatic scan_screen(input string name);
        int bad = 0;
        int fx = 0;
        int fy = 0;
        logic [6:0] fa = '0;
        logic [6:0] fe = '0;
        req  = 1'b1;
        reqx = 7'd0;
        reqy = 5'd0;
        for (int i = 0; i < NCELL; i++) begin
            @(negedge clk);
            if (ascii !== scr[i / COLS][i % COLS]) begin
                if (bad == 0) begin
                    fx = i % COLS;
                    fy = i / COLS;
                    fa = ascii;
                    fe = scr[i / COLS][i % COLS];
                end
                bad++;
            end
            if (i + 1 < NCELL) begin
                reqx = 7'((i + 1) % COLS);
                reqy = 5'((i + 1) / COLS);
            end else begin
                req = 1'b0;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d cells differ, first (%0d,%0d) ascii=%h required %h", name, bad, fx, fy, fa, fe);
        end
    endtask

    task automatic reset_seq(input string name);
        int cnt = 0;
        rst  = 1'b1;
        req  = 1'b1;
        reqx = 7'd0;
        reqy = 5'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (ascii !== 7'd0 || cursor_x !== 7'd0 || cursor_y !== 5'd0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_in_reset: ascii=%h cursor=(%0d,%0d) wr_ready=%b required 00 (0,0) 0",
                     name, ascii, cursor_x, cursor_y, wr_ready);
        end
        rst = 1'b0;
        req = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!wr_ready && cnt < 6000);
        checks++;
        if (cnt != NCELL) begin
            errors++;
            $display("FAIL %s_clear_len: wr_ready after %0d cycles, required %0d", name, cnt, NCELL);
        end
        model_clear();
    endtask

    task automatic test_reset();
        reset_seq("reset");
        scan_screen("reset_blank");
    endtask

    task automatic test_ab();
        send_byte("A");
        send_byte("B");
        req  = 1'b1;
        reqx = 7'd0;
        reqy = 5'd0;
        @(negedge clk);
        checks++;
        if (ascii !== 7'h41) begin
            errors++;
            $display("FAIL ab_read_0: ascii=%h required 41", ascii);
        end
        reqx = 7'd1;
        @(negedge clk);
        checks++;
        if (ascii !== 7'h42) begin
            errors++;
            $display("FAIL ab_read_1: ascii=%h required 42", ascii);
        end
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (ascii !== 7'h00) begin
            errors++;
            $display("FAIL ab_no_req: ascii=%h required 00", ascii);
        end
        checks++;
        if (cursor_x !== 7'd2 || cursor_y !== 5'd0) begin
            errors++;
            $display("FAIL ab_cursor: got (%0d,%0d) required (2,0)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_wrap_row();
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) send_byte("Z");
        checks++;
        if (cursor_x !== 7'd0 || cursor_y !== 5'd1) begin
            errors++;
            $display("FAIL wrap_cursor: got (%0d,%0d) required (0,1)", cursor_x, cursor_y);
        end
        send_byte(8'h0D);
        send_byte("Q");
        req  = 1'b1;
        reqx = 7'd0;
        reqy = 5'd1;
        @(negedge clk);
        checks++;
        if (ascii !== 7'h51) begin
            errors++;
            $display("FAIL wrap_q: ascii=%h required 51", ascii);
        end
        reqx = 7'd85;
        reqy = 5'd0;
        @(negedge clk);
        checks++;
        if (ascii !== 7'h5A) begin
            errors++;
            $display("FAIL wrap_last_col: ascii=%h required 5a", ascii);
        end
        req = 1'b0;
        send_byte(8'h08);
        checks++;
        if (cursor_x !== 7'd0) begin
            errors++;
            $display("FAIL bs_move: cursor_x=%0d required 0", cursor_x);
        end
        send_byte(8'h08);
    endtask

    task automatic test_read_first();
        int busy;
        logic [6:0] old;
        while (!wr_ready) @(negedge clk);
        old      = scr[my][mx];
        req      = 1'b1;
        reqx     = 7'(mx);
        reqy     = 5'(my);
        wr_valid = 1'b1;
        wr_data  = "K";
        @(negedge clk);
        wr_valid = 1'b0;
        model_apply("K", busy);
        checks++;
        if (ascii !== old) begin
            errors++;
            $display("FAIL read_first_old: ascii=%h required %h", ascii, old);
        end
        @(negedge clk);
        checks++;
        if (ascii !== 7'h4B) begin
            errors++;
            $display("FAIL read_first_new: ascii=%h required 4b", ascii);
        end
        req = 1'b0;
    endtask

    task automatic test_random_stream();
        logic [7:0] b;
        int r;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 80) b = 8'h0A;
            else if (r < 85) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 95) b = 8'($urandom_range(128, 255));
            else begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h1B;
            end
            send_byte(b);
        end
        scan_screen("random_stream");
    endtask

    task automatic test_scroll();
        int guard = 0;
        while (my < ROWS - 1 && guard < ROWS) begin
            send_byte(8'h0A);
            guard++;
        end
        for (int k = 0; k < 33; k++) begin
            send_byte(8'(8'h61 + (k % 26)));
            send_byte(8'h0A);
        end
        req  = 1'b1;
        reqx = 7'd5;
        reqy = 5'(ROWS - 1);
        @(negedge clk);
        checks++;
        if (ascii !== 7'h20) begin
            errors++;
            $display("FAIL scroll_bottom_blank: ascii=%h required 20", ascii);
        end
        req = 1'b0;
        scan_screen("scroll_wrap");
    endtask

    task automatic test_read_bounds();
        logic [6:0] x;
        logic [4:0] y;
        logic       rq;
        logic [6:0] exp;
        for (int n = 0; n < 40; n++) begin
            x  = 7'($urandom_range(0, 127));
            y  = 5'($urandom_range(0, ROWS - 1));
            rq = ($urandom_range(0, 3) != 0);
            exp = (rq && x < 7'(COLS)) ? scr[y][x] : 7'd0;
            req  = rq;
            reqx = x;
            reqy = y;
            @(negedge clk);
            checks++;
            if (ascii !== exp) begin
                errors++;
                $display("FAIL read_bounds req=%b (%0d,%0d): ascii=%h required %h", rq, x, y, ascii, exp);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_formfeed();
        send_byte(8'h0C);
        scan_screen("formfeed_blank");
    endtask

    task automatic test_rst_mid_line();
        int busy;
        send_byte("X");
        while (my < ROWS - 1) send_byte(8'h0A);
        push_byte(8'h0A, busy);
        repeat (40) @(negedge clk);
        reset_seq("rst_mid_line");
        scan_screen("rst_mid_line_blank");
    endtask

    task automatic test_rst_mid_all();
        int busy;
        send_byte("H");
        send_byte("I");
        push_byte(8'h0C, busy);
        repeat (1000) @(negedge clk);
        reset_seq("rst_mid_all");
        scan_screen("rst_mid_all_blank");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ab();
        test_wrap_row();
        test_read_first();
        test_random_stream();
        test_scroll();
        test_read_bounds();
        test_formfeed();
        test_rst_mid_line();
        test_rst_mid_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
